scan_chain_ctrl: RTL and testbench

- Drives one scan chain built from the team's mux-D scan flip-flops, which have scan-enable SE, scan-in SI and an active-high RESET.
- Takes a parallel test pattern over a valid/ready handshake and serializes it onto SI with SE high.
- Issues a single functional capture cycle, then shifts the chain out via SO and returns the captured response as a parallel word.
- Sits between the test host (BIST/SBST sequencer or JTAG bridge) and the chain: it is the driving end of the scan interface.

---
 rtl/scan_chain_ctrl.sv | 130 +++++++++++++
 tb/tb_scan_chain_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: serializes a test pattern onto SI, runs one capture cycle,
// then unloads SO into a parallel response. Optional MISR on SO enabled by SCAN_MISR_EN.
//
// state   | meaning
// IDLE    | waiting for a pattern, pat_ready high
// LOAD    | shifting pattern into chain, SE=1, MSB first
// CAPTURE | single functional cycle, SE=0
// UNLOAD  | shifting chain out via SO, SE=1, SI=0
// DONE    | response valid, waiting for rsp_ready
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic                 CK,
  input  logic                 RESET,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 busy,
  input  logic                 sig_clr,
  output logic [15:0]          sig
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] UNLOAD  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_sr_q, pat_sr_d;
  logic [CHAIN_LEN-1:0] rsp_sr_q, rsp_sr_d;
  logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_sr_d   = pat_sr_q;
    rsp_sr_d   = rsp_sr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (pat_valid) begin
          pat_sr_d = pat_data;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        pat_sr_d = {pat_sr_q[CHAIN_LEN-2:0], 1'b0};
        if (cnt_q == LAST) state_d = CAPTURE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = UNLOAD;
      end
      UNLOAD: begin
        rsp_sr_d = {rsp_sr_q[CHAIN_LEN-2:0], SO};
        if (cnt_q == LAST) begin
          state_d    = DONE;
          rsp_data_d = rsp_sr_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pat_sr_q   <= '0;
      rsp_sr_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_sr_q   <= pat_sr_d;
      rsp_sr_q   <= rsp_sr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // SE/SI come only from flops so the chain never sees input-driven glitches
  assign pat_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign SE        = (state_q == LOAD) || (state_q == UNLOAD);
  assign SI        = (state_q == LOAD) && pat_sr_q[CHAIN_LEN-1];
  assign rsp_data  = rsp_data_q;

`ifdef SCAN_MISR_EN
  logic [15:0] sig_q, sig_d;
  logic        fb;

  always_comb begin
    fb    = sig_q[15] ^ SO;
    sig_d = sig_q;
    if (sig_clr)                 sig_d = '0;
    else if (state_q == UNLOAD)  sig_d = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign sig = sig_q;
`else
  logic unused_sig_clr;
  assign unused_sig_clr = sig_clr;
  assign sig            = '0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-bit behavioural scan chain on SE/SI/SO.
module tb_scan_chain_ctrl;
  localparam int N = 8;

  logic         CK = 1'b0;
  logic         RESET, pat_valid, pat_ready, rsp_valid, rsp_ready;
  logic         SE, SI, SO, busy, sig_clr;
  logic [N-1:0] pat_data, rsp_data;
  logic [15:0]  sig;

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(4)) dut (
    .CK(CK), .RESET(RESET), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .SE(SE), .SI(SI), .SO(SO), .busy(busy),
    .sig_clr(sig_clr), .sig(sig)
  );

  // chain: shifts SI toward the SO end with SE high, captures functional data with SE low
  logic [N-1:0] chain;
  logic         cap_mode;
  logic [N-1:0] cap_val;
  always @(posedge CK or posedge RESET) begin
    if (RESET)   chain <= '0;
    else if (SE) chain <= {chain[N-2:0], SI};
    else         chain <= cap_mode ? ~chain : cap_val;
  end
  assign SO = chain[N-1];

  logic         mon_en = 1'b0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           rsp_cnt = 0;
  int           acc_cyc [4];
  logic [N-1:0] rsp_log [4];
  always @(posedge CK) begin
    if (mon_en) begin
      cyc <= cyc + 1;
      if (pat_valid && pat_ready && acc_cnt < 4) begin
        acc_cyc[acc_cnt] <= cyc;
        acc_cnt <= acc_cnt + 1;
      end
      if (rsp_valid && rsp_ready && rsp_cnt < 4) begin
        rsp_log[rsp_cnt] <= rsp_data;
        rsp_cnt <= rsp_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves the DUT in DONE, sampled at the negedge after the 17th edge past acceptance.
  task automatic run_to_done(input logic [N-1:0] pat, input logic [N-1:0] exp);
    @(negedge CK);
    chk("pat_ready_idle", {31'd0, pat_ready}, 1);
    pat_data  = pat;
    pat_valid = 1'b1;
    @(negedge CK);
    pat_valid = 1'b0;
    pat_data  = ~pat;
    for (int i = 0; i < N; i++) begin
      chk("load_se", {31'd0, SE}, 1);
      chk("load_si", {31'd0, SI}, {31'd0, pat[N-1-i]});
      @(negedge CK);
    end
    chk("capture_se", {31'd0, SE}, 0);
    chk("chain_loaded", {24'd0, chain}, {24'd0, pat});
    @(negedge CK);
    for (int i = 0; i < N; i++) begin
      chk("unload_se", {31'd0, SE}, 1);
      chk("unload_si", {31'd0, SI}, 0);
      chk("no_early_valid", {31'd0, rsp_valid}, 0);
      @(negedge CK);
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 1);
    chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp});
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge CK);
    rsp_ready = 1'b0;
    chk("idle_after_hs", {31'd0, busy}, 0);
  endtask

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] cap;
    logic [N-1:0] exp;
  } vec_t;
  vec_t vecs [4];

  logic [15:0] sig_exp;

  initial begin
    vecs[0] = '{pat: 8'hA5, cap: 8'h3C, exp: 8'h3C};
    vecs[1] = '{pat: 8'hFF, cap: 8'h00, exp: 8'h00};
    vecs[2] = '{pat: 8'h00, cap: 8'hFF, exp: 8'hFF};
    vecs[3] = '{pat: 8'h81, cap: 8'h7E, exp: 8'h7E};

    RESET = 1'b1; pat_valid = 1'b0; rsp_ready = 1'b0; sig_clr = 1'b0;
    pat_data = '0; cap_mode = 1'b0; cap_val = '0;
    repeat (2) @(negedge CK);
    chk("rst_se", {31'd0, SE}, 0);
    chk("rst_si", {31'd0, SI}, 0);
    chk("rst_pat_ready", {31'd0, pat_ready}, 1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sig", {16'd0, sig}, 0);
    RESET = 1'b0;

    for (int v = 0; v < 4; v++) begin
      cap_val = vecs[v].cap;
      run_to_done(vecs[v].pat, vecs[v].exp);
      handshake();
    end

    // response stall: held output, pattern pulse ignored
    cap_val = 8'h3C;
    run_to_done(8'hC3, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      pat_valid = (i == 1);
      pat_data  = 8'h99;
      chk("stall_valid", {31'd0, rsp_valid}, 1);
      chk("stall_data", {24'd0, rsp_data}, 8'h3C);
      chk("stall_pat_ready", {31'd0, pat_ready}, 0);
    end
    pat_valid = 1'b0;
    handshake();
    cap_val = 8'h5A;
    run_to_done(8'h11, 8'h5A);
    handshake();

    // reset in UNLOAD cycle 3
    cap_val = 8'h55;
    @(negedge CK);
    pat_data = 8'h12; pat_valid = 1'b1;
    @(negedge CK);
    pat_valid = 1'b0;
    repeat (12) @(negedge CK);
    chk("pre_rst_se", {31'd0, SE}, 1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_se", {31'd0, SE}, 0);
    chk("mid_rst_si", {31'd0, SI}, 0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_pat_ready", {31'd0, pat_ready}, 1);
    chk("mid_rst_sig", {16'd0, sig}, 0);
    @(negedge CK);
    RESET = 1'b0;

    // MISR after a 0xFF capture
    sig_clr = 1'b1;
    @(negedge CK);
    sig_clr = 1'b0;
    cap_val = 8'hFF;
    run_to_done(8'hFF, 8'hFF);
`ifdef SCAN_MISR_EN
    sig_exp = 16'h1EF0;
`else
    sig_exp = 16'h0000;
`endif
    chk("misr_sig", {16'd0, sig}, {16'd0, sig_exp});
    handshake();
    sig_clr = 1'b1;
    @(negedge CK);
    sig_clr = 1'b0;
    chk("sig_cleared", {16'd0, sig}, 0);

    // back-to-back, chain function inverts the loaded pattern
    cap_mode  = 1'b1;
    rsp_ready = 1'b1;
    mon_en    = 1'b1;
    pat_data  = 8'h5A;
    pat_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (acc_cnt < 1 && n < 100) begin @(negedge CK); n++; end
      chk("b2b_accept1", {31'd0, acc_cnt >= 1}, 1);
      pat_data = 8'h0F;
      n = 0;
      while (acc_cnt < 2 && n < 100) begin @(negedge CK); n++; end
      chk("b2b_accept2", {31'd0, acc_cnt >= 2}, 1);
      pat_valid = 1'b0;
      n = 0;
      while (rsp_cnt < 2 && n < 100) begin @(negedge CK); n++; end
      chk("b2b_rsp_count", {31'd0, rsp_cnt >= 2}, 1);
    end
    chk("b2b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 19);
    chk("b2b_rsp0", {24'd0, rsp_log[0]}, 8'hA5);
    chk("b2b_rsp1", {24'd0, rsp_log[1]}, 8'hF0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
